// File: rtl/dmem_sram_slave_pkg.sv
// dmem_sram_slave_pkg
//   Shared constants and types for the data-side SRAM slave.
//   - SIZE_* : encodings of the request size field
//   - LFSR_SEED : reset value of the random-stall LFSR (DMEM_RANDOM_STALL_EN builds)
//   - respEntry_t : one response-queue slot {rdata, err, countdown}
//   - decodeLanes : size/offset -> {legal, byte-lane enables}
package dmem_sram_slave_pkg;

    localparam logic [1:0]  SIZE_BYTE = 2'd0;
    localparam logic [1:0]  SIZE_HALF = 2'd1;
    localparam logic [1:0]  SIZE_WORD = 2'd2;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic [1:0]  countdown;
    } respEntry_t;

    typedef struct packed {
        logic       legal;
        logic [3:0] lanes;
    } laneDecode_t;

    function automatic laneDecode_t decodeLanes(input logic [1:0] size, input logic [1:0] offs);
        laneDecode_t d;
        d = '0;
        case (size)
            SIZE_BYTE: begin
                d.legal = 1'b1;
                d.lanes = 4'b0001 << offs;
            end
            SIZE_HALF: begin
                d.legal = ~offs[0];
                d.lanes = offs[1] ? 4'b1100 : 4'b0011;
            end
            SIZE_WORD: begin
                d.legal = (offs == 2'b00);
                d.lanes = 4'b1111;
            end
            default: d = '0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/dmem_resp_queue.sv
// dmem_resp_queue
//   Circular FIFO of OUTSTANDING response entries. Each entry carries its
//   response data/error and a countdown loaded with LATENCY-1 on push; the
//   head is ready once its countdown reaches zero and pops in that cycle.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   push            : write a new entry at the tail
//   pushData/Err    : payload of the new entry
//   headReady       : head entry present with countdown == 0 (pops this cycle)
//   headData/Err    : head entry payload
//   full            : all OUTSTANDING slots occupied
module dmem_resp_queue
    import dmem_sram_slave_pkg::*;
#(
    parameter int OUTSTANDING = 2,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic [31:0] pushData,
    input  logic        pushErr,
    output logic        headReady,
    output logic [31:0] headData,
    output logic        headErr,
    output logic        full
);

    localparam int PW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam int CW = $clog2(OUTSTANDING + 1);
    localparam logic [1:0] CD_START = 2'(LATENCY - 1);

    respEntry_t    entries [OUTSTANDING];
    logic [PW-1:0] headPtr;
    logic [PW-1:0] tailPtr;
    logic [CW-1:0] count;

    // Explicit wrap so non-power-of-two depths stay inside the array.
    function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
        return (p == PW'(OUTSTANDING - 1)) ? '0 : p + PW'(1);
    endfunction

    assign headReady = (count != '0) && (entries[headPtr].countdown == 2'd0);
    assign headData  = entries[headPtr].rdata;
    assign headErr   = entries[headPtr].err;
    assign full      = (count == CW'(OUTSTANDING));

    always_ff @(posedge clk) begin
        if (rst) begin
            headPtr <= '0;
            tailPtr <= '0;
            count   <= '0;
            for (int i = 0; i < OUTSTANDING; i++) begin
                entries[i] <= '0;
            end
        end else begin
            for (int i = 0; i < OUTSTANDING; i++) begin
                if (entries[i].countdown != 2'd0) begin
                    entries[i].countdown <= entries[i].countdown - 2'd1;
                end
            end
            // Later assignment wins over the decrement for the slot being filled.
            if (push) begin
                entries[tailPtr] <= '{rdata: pushData, err: pushErr, countdown: CD_START};
                tailPtr          <= nextPtr(tailPtr);
            end
            if (headReady) begin
                headPtr <= nextPtr(headPtr);
            end
            case ({push, headReady})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/dmem_sram_slave.sv
// dmem_sram_slave
//   Responder end of the data-side sram-like bus. Word-organised RAM with
//   byte-lane writes; loads read and stores write in the accept cycle, and
//   responses return in order through dmem_resp_queue after LATENCY cycles.
//   Optional macro DMEM_RANDOM_STALL_EN adds an LFSR that randomly drops
//   addr_ok (~25% of cycles) to exercise requester stall paths.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   req, wr, size : request valid, store/load, 0 byte / 1 half / 2 word / 3 illegal
//   addr, wdata   : byte address (upper bits alias), lane-aligned store data
//   addr_ok       : request accepted this cycle when req & addr_ok
//   data_ok       : one-cycle response strobe
//   rdata, err    : response word (0 for stores/illegal) and error flag
module dmem_sram_slave
    import dmem_sram_slave_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int LATENCY     = 2,
    parameter int OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata,
    output logic        err
);

    logic [31:0]       ram [2**ADDR_W];
    logic              rstD;
    logic              stall;
    logic              accept;
    logic              queueFull;
    logic              headReady;
    logic              headErr;
    logic [31:0]       headData;
    logic [31:0]       pushData;
    logic [ADDR_W-1:0] wordIdx;
    laneDecode_t       dec;
    logic              unusedAddrBits;

    assign wordIdx        = addr[ADDR_W+1:2];
    assign unusedAddrBits = &{1'b0, addr[31:ADDR_W+2]};
    assign dec            = decodeLanes(size, addr[1:0]);

    // Held low during reset and the cycle after it.
    assign addr_ok = ~rst & ~rstD & ~stall & ~queueFull;
    assign accept  = req & addr_ok;

    // Read-at-accept: a load sees every store accepted before it.
    assign pushData = (~wr & dec.legal) ? ram[wordIdx] : 32'd0;

    always_ff @(posedge clk) begin
        rstD <= rst;
    end

    always_ff @(posedge clk) begin
        if (accept && wr && dec.legal) begin
            for (int i = 0; i < 4; i++) begin
                if (dec.lanes[i]) begin
                    ram[wordIdx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

`ifdef DMEM_RANDOM_STALL_EN
    logic [15:0] lfsr;

    // Fibonacci LFSR, x^16 + x^14 + x^13 + x^11 + 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    assign stall = (lfsr[1:0] == 2'b00);
`else
    assign stall = 1'b0;
`endif

    dmem_resp_queue #(
        .OUTSTANDING (OUTSTANDING),
        .LATENCY     (LATENCY)
    ) uQueue (
        .clk       (clk),
        .rst       (rst),
        .push      (accept),
        .pushData  (pushData),
        .pushErr   (~dec.legal),
        .headReady (headReady),
        .headData  (headData),
        .headErr   (headErr),
        .full      (queueFull)
    );

    // A response due in the reset cycle is dropped with the rest of the queue.
    assign data_ok = headReady & ~rst;
    assign rdata   = data_ok ? headData : 32'd0;
    assign err     = data_ok & headErr;

endmodule

// File: tb/tb_dmem_sram_slave.sv
module tb_dmem_sram_slave;

    localparam int ADDR_W      = 10;
    localparam int LATENCY     = 2;
    localparam int OUTSTANDING = 2;

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic        req   = 1'b0;
    logic        wr    = 1'b0;
    logic [1:0]  size  = 2'd0;
    logic [31:0] addr  = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;
    logic        err;

    dmem_sram_slave #(
        .ADDR_W      (ADDR_W),
        .LATENCY     (LATENCY),
        .OUTSTANDING (OUTSTANDING)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .wr      (wr),
        .size    (size),
        .addr    (addr),
        .wdata   (wdata),
        .addr_ok (addr_ok),
        .data_ok (data_ok),
        .rdata   (rdata),
        .err     (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          arr;
    } expEntry_t;

    expEntry_t   sb[$];
    int          arrivals[$];
    logic [31:0] model [2**ADDR_W];
    int          cycle       = 0;
    int          checks      = 0;
    int          errors      = 0;
    int          lastArr     = -100;
    int          stallCycles = 0;
    int          errResps    = 0;
    logic [31:0] lastRdata   = 32'd0;

    always @(posedge clk) cycle++;

    // Response monitor: pops the scoreboard on every data_ok and flags
    // spurious, late or wrong responses.
    always @(negedge clk) begin
        expEntry_t e;
        if (data_ok) begin
            checks++;
            lastRdata = rdata;
            if (err) errResps++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL spurious_data_ok cycle=%0d rdata=%h err=%b", cycle, rdata, err);
            end else begin
                e = sb.pop_front();
                if (rdata !== e.rdata || err !== e.err || cycle != e.arr) begin
                    errors++;
                    $display("FAIL response got rdata=%h err=%b cycle=%0d expected rdata=%h err=%b cycle=%0d",
                             rdata, err, cycle, e.rdata, e.err, e.arr);
                end
            end
        end else if (sb.size() != 0 && sb[0].arr <= cycle) begin
            checks++;
            errors++;
            $display("FAIL missing_data_ok cycle=%0d expected at cycle=%0d", cycle, sb[0].arr);
            void'(sb.pop_front());
        end
    end

    // Must be called just after a posedge; returns just after the accepting posedge.
    task automatic issue(input logic w, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
        int        waited = 0;
        bit        done   = 0;
        bit        legal;
        int        idx;
        int        cnt;
        expEntry_t e;
        req = 1'b1; wr = w; size = sz; addr = a; wdata = d;
        while (!done) begin
            @(negedge clk);
            while (arrivals.size() != 0 && arrivals[0] < cycle) void'(arrivals.pop_front());
            cnt = arrivals.size();
            checks++;
`ifdef DMEM_RANDOM_STALL_EN
            if (addr_ok === 1'b1 && cnt >= OUTSTANDING) begin
`else
            if (addr_ok !== (cnt < OUTSTANDING)) begin
`endif
                errors++;
                $display("FAIL addr_ok cycle=%0d got %b with %0d outstanding", cycle, addr_ok, cnt);
            end
            if (addr_ok === 1'b1) begin
                idx = int'(a[ADDR_W+1:2]);
                case (sz)
                    2'd0:    legal = 1'b1;
                    2'd1:    legal = (a[0] == 1'b0);
                    2'd2:    legal = (a[1:0] == 2'b00);
                    default: legal = 1'b0;
                endcase
                e.err   = !legal;
                e.rdata = 32'd0;
                if (legal && w) begin
                    case (sz)
                        2'd0:    model[idx][8*a[1:0] +: 8] = d[8*a[1:0] +: 8];
                        2'd1:    model[idx][16*a[1] +: 16] = d[16*a[1] +: 16];
                        default: model[idx] = d;
                    endcase
                end else if (legal) begin
                    e.rdata = model[idx];
                end
                e.arr   = (cycle + LATENCY > lastArr + 1) ? cycle + LATENCY : lastArr + 1;
                lastArr = e.arr;
                sb.push_back(e);
                arrivals.push_back(e.arr);
                done = 1;
            end else begin
                stallCycles++;
                waited++;
                if (waited > 50) begin
                    errors++;
                    $display("FAIL accept_timeout addr=%h waited=%0d", a, waited);
                    done = 1;
                end
            end
            @(posedge clk); #1;
        end
        req = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain still %0d responses pending", sb.size());
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks += 4;
        if (addr_ok !== 1'b0) begin errors++; $display("FAIL reset_addr_ok got %b want 0", addr_ok); end
        if (data_ok !== 1'b0) begin errors++; $display("FAIL reset_data_ok got %b want 0", data_ok); end
        if (rdata !== 32'd0)  begin errors++; $display("FAIL reset_rdata got %h want 0", rdata); end
        if (err !== 1'b0)     begin errors++; $display("FAIL reset_err got %b want 0", err); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (addr_ok !== 1'b0) begin errors++; $display("FAIL post_reset_addr_ok got %b want 0", addr_ok); end
`ifndef DMEM_RANDOM_STALL_EN
        @(negedge clk);
        checks++;
        if (addr_ok !== 1'b1) begin errors++; $display("FAIL addr_ok_recover got %b want 1", addr_ok); end
`endif
        @(posedge clk); #1;
    endtask

    task automatic test_store_load();
        issue(1'b1, 2'd2, 32'h0000_0100, 32'hDEAD_BEEF);
        issue(1'b0, 2'd2, 32'h0000_0100, 32'h0);
        drain();
        checks++;
        if (lastRdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL store_load got %h want deadbeef", lastRdata); end
        // Upper address bits alias onto the same word.
        issue(1'b0, 2'd2, 32'h8000_1100, 32'h0);
        drain();
        checks++;
        if (lastRdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL alias_load got %h want deadbeef", lastRdata); end
        idle(2);
    endtask

    task automatic test_merge();
        issue(1'b1, 2'd2, 32'h0000_0200, 32'h1122_3344);
        issue(1'b1, 2'd0, 32'h0000_0201, 32'h0000_AA00);
        issue(1'b1, 2'd1, 32'h0000_0202, 32'h5566_0000);
        issue(1'b0, 2'd2, 32'h0000_0200, 32'h0);
        drain();
        checks++;
        if (lastRdata !== 32'h5566_AA44) begin errors++; $display("FAIL merge got %h want 5566aa44", lastRdata); end
        idle(2);
    endtask

    task automatic test_misaligned();
        int errBefore = errResps;
        issue(1'b1, 2'd1, 32'h0000_0203, 32'hFFFF_FFFF);
        issue(1'b1, 2'd2, 32'h0000_0202, 32'hFFFF_FFFF);
        issue(1'b1, 2'd3, 32'h0000_0200, 32'hFFFF_FFFF);
        issue(1'b0, 2'd2, 32'h0000_0200, 32'h0);
        drain();
        checks += 2;
        if (errResps - errBefore != 3) begin errors++; $display("FAIL misaligned_err_count got %0d want 3", errResps - errBefore); end
        if (lastRdata !== 32'h5566_AA44) begin errors++; $display("FAIL misaligned_ram got %h want 5566aa44", lastRdata); end
        idle(2);
    endtask

    task automatic test_full_queue();
        int stallBefore = stallCycles;
        for (int i = 0; i < 6; i++) begin
            issue(1'b0, 2'd2, (i % 2 == 0) ? 32'h0000_0100 : 32'h0000_0200, 32'h0);
        end
        drain();
`ifndef DMEM_RANDOM_STALL_EN
        // Accepts land at 0,1,3,4,6,7: two full cycles for six held requests.
        checks++;
        if (stallCycles - stallBefore != 2) begin errors++; $display("FAIL full_stalls got %0d want 2", stallCycles - stallBefore); end
`endif
        idle(2);
    endtask

    task automatic test_reset_midflight();
        issue(1'b0, 2'd2, 32'h0000_0100, 32'h0);
        issue(1'b0, 2'd2, 32'h0000_0200, 32'h0);
        rst = 1'b1;
        sb.delete();
        arrivals.delete();
        lastArr = -100;
        @(negedge clk);
        checks += 2;
        if (addr_ok !== 1'b0) begin errors++; $display("FAIL midflight_rst_addr_ok got %b want 0", addr_ok); end
        if (data_ok !== 1'b0) begin errors++; $display("FAIL midflight_rst_data_ok got %b want 0", data_ok); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (addr_ok !== 1'b0) begin errors++; $display("FAIL midflight_post_addr_ok got %b want 0", addr_ok); end
`ifndef DMEM_RANDOM_STALL_EN
        @(negedge clk);
        checks++;
        if (addr_ok !== 1'b1) begin errors++; $display("FAIL midflight_recover got %b want 1", addr_ok); end
`endif
        @(posedge clk); #1;
        idle(4);
        issue(1'b0, 2'd2, 32'h0000_0100, 32'h0);
        drain();
        checks++;
        if (lastRdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL midflight_fresh_load got %h want deadbeef", lastRdata); end
        idle(2);
    endtask

    task automatic test_random();
        int nOps;
`ifdef DMEM_RANDOM_STALL_EN
        nOps = 1000;
`else
        nOps = 300;
`endif
        for (int i = 0; i < 16; i++) begin
            issue(1'b1, 2'd2, 32'h0000_0300 + 32'(4 * i), $urandom);
        end
        for (int i = 0; i < nOps; i++) begin
            logic [31:0] a;
            logic [1:0]  sz;
            a  = ($urandom & 32'hFFFF_F000) | (32'h0000_0300 + 32'($urandom_range(0, 63)));
            sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            issue(1'($urandom_range(0, 1)), sz, a, $urandom);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        drain();
        idle(4);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog timeout at cycle %0d", cycle);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_store_load();
        test_merge();
        test_misaligned();
        test_full_queue();
        test_reset_midflight();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
